// File: rtl/qdec_qp_derive.sv
// Luma QP derivation stage that follows the delta-QP CABAC sub-FSM.
// For each quantization group it forms qPY_PRED from the left and above QpY in the current CTB,
// or from qPY_PREV when a neighbour is outside the CTB. For each CU it adds CuQpDeltaVal and
// applies the HEVC modulo wrap to give QpY. It then paints QpY into a CTB-local map that later
// QGs use as neighbours.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   slice_qp_y           SliceQpY (signed); qp_bd_offset: QpBdOffsetY
//   qg_vld/qg_rdy        QG request handshake; qg_x/qg_y origin in cells; qg_first forces slice QP
//   dqp_done             delta-QP strobe with cu_qp_delta_abs / cu_qp_delta_sign
//   cu_vld/cu_rdy        CU request handshake; cu_x/cu_y origin in cells; cu_log2_size CU size
//   qp_pred              registered qPY_PRED of the open QG
//   qp_y, qp_y_vld       QpY of the last finished CU, one-cycle update strobe
//   dqp_err              sticky flag: a delta was out of range and got clamped
module qdec_qp_derive #(
  parameter int unsigned QP_W        = 7,
  parameter int unsigned CTB_LOG2    = 6,
  parameter int unsigned MIN_CB_LOG2 = 3,
  parameter int unsigned QP_BD_MAX   = 24,
  localparam int unsigned GW         = CTB_LOG2 - MIN_CB_LOG2,
  localparam int unsigned GRID       = 1 << GW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [QP_W-1:0] slice_qp_y,
  input  logic [5:0]             qp_bd_offset,
  input  logic                   qg_vld,
  output logic                   qg_rdy,
  input  logic [GW-1:0]          qg_x,
  input  logic [GW-1:0]          qg_y,
  input  logic                   qg_first,
  input  logic                   dqp_done,
  input  logic [7:0]             cu_qp_delta_abs,
  input  logic                   cu_qp_delta_sign,
  input  logic                   cu_vld,
  output logic                   cu_rdy,
  input  logic [GW-1:0]          cu_x,
  input  logic [GW-1:0]          cu_y,
  input  logic [2:0]             cu_log2_size,
  output logic signed [QP_W-1:0] qp_pred,
  output logic signed [QP_W-1:0] qp_y,
  output logic                   qp_y_vld,
  output logic                   dqp_err
);

  localparam int unsigned DW = 10;      // signed delta, holds +/-255 before clamping
  localparam int unsigned VW = 11;      // signed wrap arithmetic, v < 3*(52+off)
  localparam int unsigned CW = GW + 2;  // cell coordinate plus span, detects overflow past GRID

  typedef enum logic [2:0] {StIdleQp, StPredQp, StWaitQp, StCalcQp, StWriteQp} state_e;

  state_e state_q, state_d;

  logic signed [QP_W-1:0] map_q [GRID][GRID];

  logic [GW-1:0]          qg_x_q, qg_y_q, cu_x_q, cu_y_q;
  logic [GW:0]            rows_q, r_q;
  logic signed [QP_W-1:0] prev_q, last_qp_q, qp_pred_q, qp_calc_q, qp_y_q;
  logic                   have_last_q, qp_y_vld_q, dqp_err_q;
  logic signed [DW-1:0]   delta_q, cu_delta_q;

  logic qg_acc, cu_acc, dqp_take, wr_last;

  // FSM; a QG request always wins over a CU request in StWaitQp
  always_comb begin
    state_d = state_q;
    qg_rdy  = 1'b0;
    cu_rdy  = 1'b0;
    qg_acc  = 1'b0;
    cu_acc  = 1'b0;
    wr_last = (r_q == rows_q - (GW+1)'(1));
    unique case (state_q)
      StIdleQp: begin
        qg_rdy = 1'b1;
        if (qg_vld) begin
          qg_acc  = 1'b1;
          state_d = StPredQp;
        end
      end
      StPredQp: state_d = StWaitQp;
      StWaitQp: begin
        qg_rdy = 1'b1;
        cu_rdy = ~qg_vld;
        if (qg_vld) begin
          qg_acc  = 1'b1;
          state_d = StPredQp;
        end else if (cu_vld) begin
          cu_acc  = 1'b1;
          state_d = StCalcQp;
        end
      end
      StCalcQp: state_d = StWriteQp;
      StWriteQp: if (wr_last) state_d = StWaitQp;
      default: state_d = StIdleQp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdleQp;
    else     state_q <= state_d;
  end

  // Delta decode and clamp to -(26+off/2)..25+off/2
  logic [5:0]           off_eff;
  logic signed [DW-1:0] dq_mag, dq_raw, dq_half, dq_hi, dq_lo, dq_new;
  logic                 dq_oor;

  always_comb begin
    off_eff  = (qp_bd_offset > 6'(QP_BD_MAX)) ? 6'(QP_BD_MAX) : qp_bd_offset;
    dq_mag   = DW'(cu_qp_delta_abs);
    dq_raw   = cu_qp_delta_sign ? -dq_mag : dq_mag;
    dq_half  = DW'(off_eff >> 1);
    dq_hi    = DW'(25) + dq_half;
    dq_lo    = -(DW'(26) + dq_half);
    dq_new   = dq_raw;
    dq_oor   = 1'b0;
    if (dq_raw > dq_hi) begin
      dq_new = dq_hi;
      dq_oor = 1'b1;
    end else if (dq_raw < dq_lo) begin
      dq_new = dq_lo;
      dq_oor = 1'b1;
    end
    // Deltas are ignored while no QG is open, except one arriving with the QG itself
    dqp_take = dqp_done & ((state_q != StIdleQp) | qg_acc);
  end

  // qPY_PRED = (A + B + 1) >> 1 using neighbours inside the CTB
  logic signed [QP_W-1:0] nb_a, nb_b, pred_d;
  logic signed [QP_W:0]   pred_sum, pred_half;

  always_comb begin
    nb_a      = (qg_x_q == '0) ? prev_q : map_q[qg_y_q][qg_x_q - GW'(1)];
    nb_b      = (qg_y_q == '0) ? prev_q : map_q[qg_y_q - GW'(1)][qg_x_q];
    pred_sum  = {nb_a[QP_W-1], nb_a} + {nb_b[QP_W-1], nb_b} + (QP_W+1)'(1);
    pred_half = pred_sum >>> 1;
    pred_d    = pred_half[QP_W-1:0];
  end

  // QpY wrap: the biased sum is always positive and below 3*(52+off), so two conditional
  // subtracts of 52+off give the modulus
  logic signed [VW-1:0]   v0, v1, v2, vm, voff, vres;
  logic signed [QP_W-1:0] qp_calc_d;

  always_comb begin
    voff      = VW'(off_eff);
    vm        = VW'(52) + voff;
    v0        = VW'(qp_pred_q) + VW'(cu_delta_q) + VW'(52) + (voff <<< 1);
    v1        = (v0 >= vm) ? v0 - vm : v0;
    v2        = (v1 >= vm) ? v1 - vm : v1;
    vres      = v2 - voff;
    qp_calc_d = vres[QP_W-1:0];
  end

  // CU span in cells; out-of-range sizes saturate to a full CTB
  logic [2:0]  size_sh;
  logic [GW:0] rows_d;

  always_comb begin
    size_sh = cu_log2_size - 3'(MIN_CB_LOG2);
    rows_d  = (size_sh > 3'(GW)) ? (GW+1)'(GRID) : ((GW+1)'(1) << size_sh);
  end

  // One map row per WRITE cycle; cells past the CTB edge are dropped
  logic [CW-1:0]   row_idx, col_lo, col_hi;
  logic [GRID-1:0] col_mask;
  logic            row_ok;
  logic [GW-1:0]   wr_row;

  always_comb begin
    row_idx = CW'(cu_y_q) + CW'(r_q);
    col_lo  = CW'(cu_x_q);
    col_hi  = col_lo + CW'(rows_q);
    for (int c = 0; c < GRID; c++) begin
      col_mask[c] = (CW'(c) >= col_lo) && (CW'(c) < col_hi);
    end
    row_ok = row_idx < CW'(GRID);
    wr_row = row_idx[GW-1:0];
  end

  // Map contents are don't-care after reset, so no reset on the array
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StWriteQp) && row_ok) begin
      for (int c = 0; c < GRID; c++) begin
        if (col_mask[c]) map_q[wr_row][c] <= qp_calc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qg_x_q      <= '0;
      qg_y_q      <= '0;
      cu_x_q      <= '0;
      cu_y_q      <= '0;
      rows_q      <= '0;
      r_q         <= '0;
      prev_q      <= '0;
      last_qp_q   <= '0;
      have_last_q <= 1'b0;
      qp_pred_q   <= '0;
      qp_calc_q   <= '0;
      qp_y_q      <= '0;
      qp_y_vld_q  <= 1'b0;
      dqp_err_q   <= 1'b0;
      delta_q     <= '0;
      cu_delta_q  <= '0;
    end else begin
      qp_y_vld_q <= 1'b0;

      if (dqp_take) begin
        delta_q <= dq_new;
        if (dq_oor) dqp_err_q <= 1'b1;
      end else if (qg_acc) begin
        delta_q <= '0;
      end

      if (qg_acc) begin
        qg_x_q <= qg_x;
        qg_y_q <= qg_y;
        // Until a CU has finished, qPY_PREV falls back to the slice QP
        prev_q <= (qg_first || !have_last_q) ? slice_qp_y : last_qp_q;
      end

      if (state_q == StPredQp) qp_pred_q <= pred_d;

      if (cu_acc) begin
        cu_x_q     <= cu_x;
        cu_y_q     <= cu_y;
        rows_q     <= rows_d;
        r_q        <= '0;
        cu_delta_q <= dqp_take ? dq_new : delta_q;
      end

      if (state_q == StCalcQp) qp_calc_q <= qp_calc_d;

      if (state_q == StWriteQp) begin
        r_q <= r_q + (GW+1)'(1);
        if (wr_last) begin
          qp_y_q      <= qp_calc_q;
          qp_y_vld_q  <= 1'b1;
          last_qp_q   <= qp_calc_q;
          have_last_q <= 1'b1;
        end
      end
    end
  end

  assign qp_pred  = qp_pred_q;
  assign qp_y     = qp_y_q;
  assign qp_y_vld = qp_y_vld_q;
  assign dqp_err  = dqp_err_q;

endmodule
